// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 timing, derived totals,
// and the counter/colour types used by the generator and game components.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       rgb_t;

  // Narrow an integer timing value to the 10-bit counter domain.
  function automatic cnt_t to_cnt(input int value);
    return cnt_t'(value);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with count enable; wrap pulses on the enabled clock
// where the count rolls from MODULUS-1 back to zero.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int MODULUS = H_TOTAL
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output cnt_t count,
  output logic wrap
);

  localparam cnt_t LAST = to_cnt(MODULUS - 1);

  assign wrap = en && (count == LAST);

  // Count up when enabled, rolling over at the modulus; active-low sync reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + cnt_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running h/v counters exposed as col/row, with
// sync, blanking, visible flag and a frame tick all registered one clock
// behind the counters so they stay aligned with the registered pixel colour.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] row,
  output logic [9:0] col,
  input  logic [2:0] rgb_in,
  output logic [2:0] rgb_out,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       tick
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_VIS_C    = to_cnt(H_VISIBLE);
  localparam cnt_t V_VIS_C    = to_cnt(V_VISIBLE);
  localparam cnt_t HS_FIRST_C = to_cnt(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_LAST_C  = to_cnt(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST_C = to_cnt(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_LAST_C  = to_cnt(V_VISIBLE + V_FRONT + V_SYNC - 1);

  cnt_t h_count;
  cnt_t v_count;
  logic h_wrap;
  // The end-of-frame pulse from the vertical counter has no consumer here.
  logic v_wrap_unused;

  logic active;
  logic in_hsync;
  logic in_vsync;
  logic vblank_start;

  mod_counter #(.MODULUS(H_TOT)) u_h_counter (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .count (h_count),
    .wrap  (h_wrap)
  );

  // The line counter advances only on the last pixel of each line.
  mod_counter #(.MODULUS(V_TOT)) u_v_counter (
    .clock (clock),
    .reset (reset),
    .en    (h_wrap),
    .count (v_count),
    .wrap  (v_wrap_unused)
  );

  // Components see the live counters with zero latency.
  assign col = h_count;
  assign row = v_count;

  // Decode the raster regions from the current counter values.
  always_comb begin
    active       = (h_count < H_VIS_C) && (v_count < V_VIS_C);
    in_hsync     = (h_count >= HS_FIRST_C) && (h_count <= HS_LAST_C);
    in_vsync     = (v_count >= VS_FIRST_C) && (v_count <= VS_LAST_C);
    vblank_start = (h_count == '0) && (v_count == V_VIS_C);
  end

  // Register colour, syncs, visible and tick together so they share one clock
  // of delay; reset forces a blank, sync-idle output so no partial pulse remains.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rgb_out <= 3'b000;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      visible <= 1'b0;
      tick    <= 1'b0;
    end else begin
      rgb_out <= active ? rgb_in : 3'b000;
      hsync   <= !in_hsync;
      vsync   <= !in_vsync;
      visible <= active;
      tick    <= vblank_start;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (30 x 17) so whole frames stay
// short; a reference raster model pushes the expected post-edge outputs to a
// scoreboard queue and each scenario pops and compares after the edge.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] row, col;
  logic [2:0] rgb_in, rgb_out;
  logic       hsync, vsync, visible, tick;

  int mode = 0;
  int mh = 0;
  int mv = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [9:0] row;
    logic [9:0] col;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       tk;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .rgb_in  (rgb_in),
    .rgb_out (rgb_out),
    .hsync   (hsync),
    .vsync   (vsync),
    .visible (visible),
    .tick    (tick)
  );

  function automatic logic [2:0] pattern(input int m, input int h, input int v);
    logic [9:0] s;
    if (m == 0) return 3'b111;
    s = 10'(h + 2 * v);
    return s[2:0];
  endfunction

  // Game-component stand-in: colour is a combinational function of row/col.
  always_comb rgb_in = pattern(mode, int'(col), int'(row));

  // Predict the outputs the coming edge will produce, queue them, take the edge.
  task automatic step();
    exp_t e;
    int nh, nv;
    bit act;
    if (!reset) begin
      nh = 0; nv = 0;
      e.rgb = 3'b000; e.hs = 1'b1; e.vs = 1'b1; e.vis = 1'b0; e.tk = 1'b0;
    end else begin
      act   = (mh < HV) && (mv < VV);
      e.rgb = act ? pattern(mode, mh, mv) : 3'b000;
      e.hs  = !((mh >= HV + HF) && (mh < HV + HF + HS));
      e.vs  = !((mv >= VV + VF) && (mv < VV + VF + VS));
      e.vis = act;
      e.tk  = (mh == 0) && (mv == VV);
      nh    = (mh == HT - 1) ? 0 : mh + 1;
      nv    = (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
    end
    e.row = 10'(nv);
    e.col = 10'(nh);
    sb.push_back(e);
    @(posedge clock);
    mh = nh;
    mv = nv;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    repeat (3) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (row !== e.row || col !== e.col || rgb_out !== e.rgb || hsync !== e.hs ||
          vsync !== e.vs || visible !== e.vis || tick !== e.tk) begin
        n_fail++;
        $display("FAIL reset_state: got row=%0d col=%0d rgb=%b hs=%b vs=%b vis=%b tick=%b, want 0 0 000 1 1 0 0",
                 row, col, rgb_out, hsync, vsync, visible, tick);
      end
    end
  endtask

  task automatic test_counting();
    exp_t e;
    reset = 1'b1;
    #1;
    n_tests++;
    if (row !== 10'd0 || col !== 10'd0) begin
      n_fail++;
      $display("FAIL release_origin: got row=%0d col=%0d, want 0 0", row, col);
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (row !== e.row || col !== e.col) begin
        n_fail++;
        $display("FAIL counters: got row=%0d col=%0d, want row=%0d col=%0d", row, col, e.row, e.col);
      end
      if (i == 0) begin
        n_tests++;
        if (visible !== 1'b1) begin
          n_fail++;
          $display("FAIL visible_after_release: got %b, want 1", visible);
        end
      end
      if (i == HT - 1) begin
        n_tests++;
        if (row !== 10'd1 || col !== 10'd0) begin
          n_fail++;
          $display("FAIL one_line: got row=%0d col=%0d, want 1 0", row, col);
        end
      end
    end
    n_tests++;
    if (row !== 10'd0 || col !== 10'd0) begin
      n_fail++;
      $display("FAIL frame_wrap: got row=%0d col=%0d, want 0 0", row, col);
    end
  endtask

  task automatic test_hsync();
    exp_t e;
    logic prev = 1'b1;
    int run = 0, runs = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (hsync !== e.hs) begin
        n_fail++;
        $display("FAIL hsync: got %b, want %b at col=%0d row=%0d", hsync, e.hs, mh, mv);
      end
      if (prev === 1'b1 && hsync === 1'b0) begin
        n_tests++;
        if (mh != HV + HF + 1) begin
          n_fail++;
          $display("FAIL hsync_start: fell with counter col=%0d, want %0d", mh, HV + HF + 1);
        end
      end
      if (hsync === 1'b0) run++;
      if (prev === 1'b0 && hsync === 1'b1) begin
        runs++;
        n_tests++;
        if (run != HS) begin
          n_fail++;
          $display("FAIL hsync_width: got %0d clocks, want %0d", run, HS);
        end
        run = 0;
      end
      prev = hsync;
    end
    n_tests++;
    if (runs != 3) begin
      n_fail++;
      $display("FAIL hsync_count: got %0d pulses, want 3", runs);
    end
  endtask

  task automatic test_vsync();
    exp_t e;
    logic prev = 1'b1;
    int run = 0, runs = 0, last_fall = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (vsync !== e.vs) begin
        n_fail++;
        $display("FAIL vsync: got %b, want %b at col=%0d row=%0d", vsync, e.vs, mh, mv);
      end
      if (prev === 1'b1 && vsync === 1'b0) begin
        n_tests++;
        if (mh != 1 || mv != VV + VF) begin
          n_fail++;
          $display("FAIL vsync_start: fell at col=%0d row=%0d, want col=1 row=%0d", mh, mv, VV + VF);
        end
        if (last_fall >= 0) begin
          n_tests++;
          if (i - last_fall != FRAME) begin
            n_fail++;
            $display("FAIL vsync_period: got %0d clocks, want %0d", i - last_fall, FRAME);
          end
        end
        last_fall = i;
      end
      if (vsync === 1'b0) run++;
      if (prev === 1'b0 && vsync === 1'b1) begin
        runs++;
        n_tests++;
        if (run != VS * HT) begin
          n_fail++;
          $display("FAIL vsync_width: got %0d clocks, want %0d", run, VS * HT);
        end
        run = 0;
      end
      prev = vsync;
    end
    n_tests++;
    if (runs != 2) begin
      n_fail++;
      $display("FAIL vsync_count: got %0d pulses, want 2", runs);
    end
  endtask

  task automatic test_rgb_visible();
    exp_t e;
    int lit = 0;
    mode = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (rgb_out !== e.rgb || visible !== e.vis || visible !== (rgb_out == 3'b111)) begin
        n_fail++;
        $display("FAIL rgb_white: got rgb=%b vis=%b, want rgb=%b vis=%b", rgb_out, visible, e.rgb, e.vis);
      end
      if (rgb_out === 3'b111) lit++;
    end
    n_tests++;
    if (lit != HV * VV) begin
      n_fail++;
      $display("FAIL rgb_lit_count: got %0d, want %0d", lit, HV * VV);
    end
    mode = 1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (rgb_out !== e.rgb || visible !== e.vis) begin
        n_fail++;
        $display("FAIL rgb_pattern: got rgb=%b vis=%b, want rgb=%b vis=%b", rgb_out, visible, e.rgb, e.vis);
      end
    end
  endtask

  task automatic test_tick();
    exp_t e;
    int pulses = 0, last = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (tick !== e.tk) begin
        n_fail++;
        $display("FAIL tick: got %b, want %b at col=%0d row=%0d", tick, e.tk, mh, mv);
      end
      if (tick === 1'b1) begin
        pulses++;
        n_tests++;
        if (mh != 1 || mv != VV) begin
          n_fail++;
          $display("FAIL tick_position: at col=%0d row=%0d, want col=1 row=%0d", mh, mv, VV);
        end
        if (last >= 0) begin
          n_tests++;
          if (i - last != FRAME) begin
            n_fail++;
            $display("FAIL tick_spacing: got %0d, want %0d", i - last, FRAME);
          end
        end
        last = i;
      end
    end
    n_tests++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL tick_count: got %0d, want 3", pulses);
    end
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    int budget = 0;
    while (!(mh == HV / 2 && mv == VV / 2) && budget < FRAME + 1) begin
      step();
      e = sb.pop_front();
      budget++;
    end
    n_tests++;
    if (row !== 10'(VV / 2) || col !== 10'(HV / 2)) begin
      n_fail++;
      $display("FAIL reset_target: got row=%0d col=%0d, want %0d %0d", row, col, VV / 2, HV / 2);
    end
    reset = 1'b0;
    step();
    e = sb.pop_front();
    n_tests++;
    if (row !== 10'd0 || col !== 10'd0 || rgb_out !== 3'b000 || hsync !== 1'b1 ||
        vsync !== 1'b1 || visible !== 1'b0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got row=%0d col=%0d rgb=%b hs=%b vs=%b vis=%b tick=%b, want 0 0 000 1 1 0 0",
               row, col, rgb_out, hsync, vsync, visible, tick);
    end
    reset = 1'b1;
    for (int i = 0; i < 2 * HT; i++) begin
      step();
      e = sb.pop_front();
      n_tests++;
      if (row !== e.row || col !== e.col || visible !== e.vis || rgb_out !== e.rgb || hsync !== e.hs) begin
        n_fail++;
        $display("FAIL restart: got row=%0d col=%0d vis=%b rgb=%b hs=%b, want row=%0d col=%0d vis=%b rgb=%b hs=%b",
                 row, col, visible, rgb_out, hsync, e.row, e.col, e.vis, e.rgb, e.hs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_hsync();
    test_vsync();
    test_rgb_visible();
    test_tick();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL run on one clock; reset is synchronous and active-low.
REQ-010 clock  input  1  pixel clock, 25 MHz nominal, rising edge.
REQ-011 reset  input  1  synchronous reset, active LOW.
REQ-012 row  output  10  current line counter, fed to game components.
REQ-013 col  output  10  current pixel counter, fed to game components.
REQ-014 rgb_in  input  3  pixel colour returned by components for the current row/col.
REQ-015 rgb_out  output  3  blanked, registered colour to the DAC pins.
REQ-016 hsync  output  1  horizontal sync, active LOW.
REQ-017 vsync  output  1  vertical sync, active LOW.
REQ-018 visible  output  1  high while rgb_out carries an active-area pixel.
REQ-019 tick  output  1  one-clock game-update pulse, once per frame.

Function
REQ-020 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-021 h_count SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-022 v_count SHALL increment only on clocks where h_count = H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same clock.
REQ-023 col SHALL equal h_count and row SHALL equal v_count, driven directly from the counter registers with zero latency.
REQ-024 rgb_in is a same-cycle combinational function of row/col; the block SHALL register it, giving one clock of latency.
REQ-025 rgb_out SHALL equal the registered rgb_in when the sampled counters satisfy h<H_VISIBLE and v<V_VISIBLE, otherwise 3'b000.
REQ-026 visible SHALL be the registered active-area condition, aligned to rgb_out.
REQ-027 hsync SHALL be registered and LOW for sampled h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] ([656,751]).
REQ-028 vsync SHALL be registered and LOW for sampled v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] ([490,491]), for whole lines.
REQ-029 hsync, vsync, visible and rgb_out SHALL share the same one-clock delay relative to the counters.
REQ-030 tick SHALL be a registered one-clock pulse asserted after the clock where h_count=0 and v_count=V_VISIBLE, i.e. at the start of vertical blank.
REQ-031 All arithmetic SHALL be 10-bit unsigned; no counter may exceed its TOTAL-1.

Reset
REQ-032 While reset is low at a rising edge: h_count=0, v_count=0, rgb_out=3'b000, hsync=1, vsync=1, visible=0, tick=0.
REQ-033 Reset asserted mid-frame SHALL take effect at the next edge regardless of counter state; no partial sync pulse SHALL persist.
REQ-034 On the first edge after reset is released, counting SHALL resume from (row 0, col 0); visible SHALL go high on the following clock.

Structure
REQ-035 The timing defaults and the derived H_TOTAL/V_TOTAL constants SHALL live in a shared package, vga_timing_pkg, also used by game components for screen limits.
REQ-036 Each axis SHALL use the sub-module mod_counter (parameterised modulus, enable input, wrap pulse output); the block instantiates it twice, with the h wrap driving the v enable.

Verification
REQ-037 Release reset -> row=0, col=0; 800 clocks later -> row=1, col=0; after 420000 clocks -> back to (0,0).
REQ-038 Check hsync per line -> LOW for exactly 96 consecutive clocks, first LOW output one clock after h_count=656.
REQ-039 Check vsync per frame -> LOW for exactly 1600 clocks, starting one clock after (h=0, v=490); period 420000 clocks.
REQ-040 Hold rgb_in=3'b111 -> rgb_out=111 for exactly 640 clocks per line on lines 0-479, 000 elsewhere; visible matches rgb_out.
REQ-041 Count tick over 3 frames -> exactly 3 one-clock pulses spaced 420000 clocks, first pulse one clock after (h=0, v=480).
REQ-042 Pull reset low at (col 320, row 200) for 1 edge -> next edge shows all REQ-032 values; after release, counting restarts at (0,0).
